// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core fetch path.
// Widths, PC step and the fetch buffer entry bundle.
package core_pkg;

    localparam int L_WIDTH = 16;
    localparam int PC_STEP = 2;
    localparam logic [L_WIDTH-1:0] RESET_VECTOR = 16'h0000;

    typedef struct packed {
        logic [L_WIDTH-1:0] pc;
        logic [L_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched {pc, instr} entries.
// Flush wins over push/pop; reset also clears entry storage.
module fetch_buffer
    import core_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic [$clog2(Depth):0]   count
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [Depth];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Power-of-two depth lets the pointers wrap naturally.
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: owns the PC, reads combinational instruction memory,
// buffers words for decode and handles redirect/flush.
module instruction_fetch_unit
    import core_pkg::*;
#(
    parameter int             l           = L_WIDTH,
    parameter int             Depth       = 2,
    parameter logic [l-1:0]   ResetVector = RESET_VECTOR
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Enable,
    output logic [l-1:0]  Address,
    input  logic [l-1:0]  Instruction,
    input  logic          Redirect,
    input  logic [l-1:0]  RedirectTarget,
    output logic          Misaligned,
    output logic          InstrValid,
    output logic [l-1:0]  InstrOut,
    output logic [l-1:0]  InstrPC,
    input  logic          InstrReady,
    output logic [l-1:0]  FetchCount
);

    localparam int CW = $clog2(Depth) + 1;

    logic [l-1:0]   pc;
    logic [CW-1:0]  count;
    logic           full;
    logic           push;
    logic           pop;
    fetch_entry_t   wentry;
    fetch_entry_t   head;

    assign Address    = pc;
    assign full       = (count == CW'(Depth));
    assign InstrValid = (count != '0);
    assign InstrOut   = head.instr;
    assign InstrPC    = head.pc;

    // A redirect discards any handshake offered in the same cycle.
    always_comb begin
        pop    = 1'b0;
        push   = 1'b0;
        wentry = '0;
        pop    = InstrValid & InstrReady & ~Redirect;
        push   = Enable & ~Redirect & (~full | pop);
        wentry = '{pc: pc, instr: Instruction};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc         <= ResetVector;
            Misaligned <= 1'b0;
            FetchCount <= '0;
        end else begin
            Misaligned <= Redirect & RedirectTarget[0];
            if (Redirect) begin
                pc <= {RedirectTarget[l-1:1], 1'b0};
            end else if (push) begin
                pc <= pc + l'(PC_STEP);
            end
            if (push) begin
                FetchCount <= FetchCount + l'(1);
            end
        end
    end

    fetch_buffer #(
        .Depth (Depth)
    ) u_buf (
        .clk   (Clk),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .flush (Redirect),
        .din   (wentry),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed vector bench for instruction_fetch_unit.
// Table rows give inputs for one edge and the expected post-edge outputs.
module tb_instruction_fetch_unit;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Enable;
    logic [15:0] Address;
    logic [15:0] Instruction;
    logic        Redirect;
    logic [15:0] RedirectTarget;
    logic        Misaligned;
    logic        InstrValid;
    logic [15:0] InstrOut;
    logic [15:0] InstrPC;
    logic        InstrReady;
    logic [15:0] FetchCount;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        redir;
        logic [15:0] tgt;
        logic        v;
        logic [15:0] pc;
        logic [15:0] ins;
        logic [15:0] addr;
        logic [15:0] fc;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    always #5 Clk = ~Clk;

    always_comb begin
        unique case (Address)
            16'h0000: Instruction = 16'h6002;
            16'h0002: Instruction = 16'h6403;
            16'h0004: Instruction = 16'hE201;
            16'h0006: Instruction = 16'h467C;
            default:  Instruction = 16'h2001;
        endcase
    end

    instruction_fetch_unit dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Enable         (Enable),
        .Address        (Address),
        .Instruction    (Instruction),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .Misaligned     (Misaligned),
        .InstrValid     (InstrValid),
        .InstrOut       (InstrOut),
        .InstrPC        (InstrPC),
        .InstrReady     (InstrReady),
        .FetchCount     (FetchCount)
    );

    function automatic vec_t mk(
        logic en, logic rdy, logic redir, logic [15:0] tgt,
        logic v, logic [15:0] pc, logic [15:0] ins,
        logic [15:0] addr, logic [15:0] fc, logic mis);
        vec_t r;
        r.en = en; r.rdy = rdy; r.redir = redir; r.tgt = tgt;
        r.v = v; r.pc = pc; r.ins = ins;
        r.addr = addr; r.fc = fc; r.mis = mis;
        return r;
    endfunction

    task automatic chk(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic rdy,
                         input logic redir, input logic [15:0] tgt);
        Enable = en;
        InstrReady = rdy;
        Redirect = redir;
        RedirectTarget = tgt;
    endtask

    initial begin
        // Stream, stall, misaligned redirect, wrap, enable toggling.
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0000,16'h6002,16'h0002,16'd1,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0002,16'h6403,16'h0004,16'd2,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0004,16'hE201,16'h0006,16'd3,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0006,16'h467C,16'h0008,16'd4,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0008,16'h2001,16'h000A,16'd5,L));
        vecs.push_back(mk(H,H,H,16'h0000, L,16'h0000,16'h0000,16'h0000,16'd5,L));
        vecs.push_back(mk(H,L,L,16'h0000, H,16'h0000,16'h6002,16'h0002,16'd6,L));
        vecs.push_back(mk(H,L,L,16'h0000, H,16'h0000,16'h6002,16'h0004,16'd7,L));
        vecs.push_back(mk(H,L,L,16'h0000, H,16'h0000,16'h6002,16'h0004,16'd7,L));
        vecs.push_back(mk(H,L,L,16'h0000, H,16'h0000,16'h6002,16'h0004,16'd7,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0002,16'h6403,16'h0006,16'd8,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0004,16'hE201,16'h0008,16'd9,L));
        vecs.push_back(mk(H,H,H,16'h0005, L,16'h0000,16'h0000,16'h0004,16'd9,H));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0004,16'hE201,16'h0006,16'd10,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0006,16'h467C,16'h0008,16'd11,L));
        vecs.push_back(mk(H,H,H,16'hFFFC, L,16'h0000,16'h0000,16'hFFFC,16'd11,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'hFFFC,16'h2001,16'hFFFE,16'd12,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'hFFFE,16'h2001,16'h0000,16'd13,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0000,16'h6002,16'h0002,16'd14,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0002,16'h6403,16'h0004,16'd15,L));
        vecs.push_back(mk(L,H,L,16'h0000, L,16'h0000,16'h0000,16'h0004,16'd15,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0004,16'hE201,16'h0006,16'd16,L));
        vecs.push_back(mk(L,H,L,16'h0000, L,16'h0000,16'h0000,16'h0006,16'd16,L));
        vecs.push_back(mk(H,H,L,16'h0000, H,16'h0006,16'h467C,16'h0008,16'd17,L));
        vecs.push_back(mk(L,H,L,16'h0000, L,16'h0000,16'h0000,16'h0008,16'd17,L));

        Reset = 1'b1;
        drive(L, L, L, 16'h0000);
        step();
        step();
        chk("reset_valid", {15'd0, InstrValid}, 16'h0000);
        chk("reset_addr", Address, 16'h0000);
        chk("reset_fc", FetchCount, 16'h0000);
        chk("reset_mis", {15'd0, Misaligned}, 16'h0000);
        chk("reset_instr", InstrOut, 16'h0000);
        chk("reset_pc", InstrPC, 16'h0000);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].rdy, vecs[i].redir, vecs[i].tgt);
            step();
            chk($sformatf("row%0d_valid", i), {15'd0, InstrValid},
                {15'd0, vecs[i].v});
            chk($sformatf("row%0d_addr", i), Address, vecs[i].addr);
            chk($sformatf("row%0d_fc", i), FetchCount, vecs[i].fc);
            chk($sformatf("row%0d_mis", i), {15'd0, Misaligned},
                {15'd0, vecs[i].mis});
            if (vecs[i].v) begin
                chk($sformatf("row%0d_ipc", i), InstrPC, vecs[i].pc);
                chk($sformatf("row%0d_ins", i), InstrOut, vecs[i].ins);
            end
        end

        // Fill two words, then reset beats a concurrent misaligned redirect.
        drive(H, L, L, 16'h0000);
        step();
        step();
        chk("fill_valid", {15'd0, InstrValid}, 16'h0001);
        chk("fill_addr", Address, 16'h000C);
        chk("fill_fc", FetchCount, 16'd19);
        chk("fill_head", InstrPC, 16'h0008);
        Reset = 1'b1;
        drive(H, H, H, 16'h0101);
        step();
        chk("midrst_valid", {15'd0, InstrValid}, 16'h0000);
        chk("midrst_addr", Address, 16'h0000);
        chk("midrst_fc", FetchCount, 16'h0000);
        chk("midrst_mis", {15'd0, Misaligned}, 16'h0000);
        chk("midrst_instr", InstrOut, 16'h0000);
        Reset = 1'b0;
        drive(H, H, L, 16'h0000);
        step();
        chk("refetch_valid", {15'd0, InstrValid}, 16'h0001);
        chk("refetch_ins", InstrOut, 16'h6002);
        chk("refetch_pc", InstrPC, 16'h0000);
        chk("refetch_fc", FetchCount, 16'd1);

        // Enable low with a pending word: it still drains, PC holds.
        drive(L, H, L, 16'h0000);
        step();
        chk("drain_valid", {15'd0, InstrValid}, 16'h0000);
        chk("drain_addr", Address, 16'h0002);
        chk("drain_fc", FetchCount, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
